// File: rtl/debounce_sync.sv
// Button/switch conditioner: synchronizer, debounce FSM with stability counter, edge pulses.
// Optional press counter enabled by defining DEBOUNCE_PRESS_COUNT_EN.
//
// state   | meaning
// IDLE_LO | committed low, watching for s=1
// WAIT_HI | qualifying a rising candidate
// IDLE_HI | committed high, watching for s=0
// WAIT_LO | qualifying a falling candidate
module debounce_sync #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       a,
   output logic       rise,
   output logic       fall,
   output logic       busy
`ifdef DEBOUNCE_PRESS_COUNT_EN
   ,
   output logic [7:0] press_count
`endif
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   state_t                 r_state, w_state_nxt;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic                   r_a, r_rise, r_fall;
   logic                   w_a_nxt, w_rise_nxt, w_fall_nxt;

   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE_LO;
         r_cnt   <= '0;
         r_a     <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_a     <= w_a_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_a_nxt     = r_a;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      unique case (r_state)
         IDLE_LO: begin
            w_cnt_nxt = '0;
            if (w_s) begin
               w_state_nxt = WAIT_HI;
               w_cnt_nxt   = CW'(1);
            end
         end
         WAIT_HI: begin
            if (!w_s) begin
               w_state_nxt = IDLE_LO;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE_HI;
               w_cnt_nxt   = '0;
               w_a_nxt     = 1'b1;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         IDLE_HI: begin
            w_cnt_nxt = '0;
            if (!w_s) begin
               w_state_nxt = WAIT_LO;
               w_cnt_nxt   = CW'(1);
            end
         end
         WAIT_LO: begin
            if (w_s) begin
               w_state_nxt = IDLE_HI;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE_LO;
               w_cnt_nxt   = '0;
               w_a_nxt     = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE_LO;
            w_cnt_nxt   = '0;
            w_a_nxt     = 1'b0;
         end
      endcase
   end

   assign a    = r_a;
   assign rise = r_rise;
   assign fall = r_fall;
   assign busy = (r_state == WAIT_HI) || (r_state == WAIT_LO);

`ifdef DEBOUNCE_PRESS_COUNT_EN
   logic [7:0] r_press;

   // counts the registered rise pulse, so it lands one cycle after the rise
   always_ff @(posedge clk) begin
      if (rst)       r_press <= '0;
      else if (r_rise) r_press <= r_press + 8'd1;
   end

   assign press_count = r_press;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: expected rise/fall events are queued by the
// stimulus with their commit edge; a monitor pops and checks each observed pulse.
module tb_debounce_sync;

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic a, rise, fall, busy;
`ifdef DEBOUNCE_PRESS_COUNT_EN
   logic [7:0] press_count;
`endif

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   typedef struct {
      bit is_rise;
      int cyc;
   } ev_t;

   ev_t exp_q[$];

   debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_in),
      .a      (a),
      .rise   (rise),
      .fall   (fall),
      .busy   (busy)
`ifdef DEBOUNCE_PRESS_COUNT_EN
      ,
      .press_count (press_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic push(input bit is_rise, input int cyc);
      ev_t e;
      e.is_rise = is_rise;
      e.cyc     = cyc;
      exp_q.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // monitor: every pulse must match the head of the expected queue
   always @(negedge clk) begin
      if (rise === 1'b1 || fall === 1'b1) begin
         check("rise_fall_exclusive", int'(rise && fall), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse_rise", int'(rise), 0);
            check("unexpected_pulse_fall", int'(fall), 0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("pulse_kind_rise", int'(rise), int'(e.is_rise));
            check("pulse_edge", edge_n, e.cyc);
            check("a_with_pulse", int'(a), int'(e.is_rise));
         end
      end
   end

   int bpat[19] = '{1,0,1,1,0,1,1,1,1,1,1,0,0,0,0,0,0,0,0};

   initial begin
      int t0;
      rst    = 1'b1;
      btn_in = 1'b1;

      // reset held 3 cycles with button high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_a", int'(a), 0);
         check("rst_rise", int'(rise), 0);
         check("rst_fall", int'(fall), 0);
         check("rst_busy", int'(busy), 0);
      end
`ifdef DEBOUNCE_PRESS_COUNT_EN
      check("rst_press_count", int'(press_count), 0);
`endif
      // release with button still high: commits on 6th edge after release
      rst = 1'b0;
      t0  = edge_n;
      push(1'b1, t0 + 6);
      cycles(10);
      check("post_rst_a_high", int'(a), 1);
      btn_in = 1'b0;
      t0 = edge_n;
      push(1'b0, t0 + 6);
      cycles(10);
      check("post_rst_a_low", int'(a), 0);

      // clean press: busy on edges 3..5, a from edge 6
      btn_in = 1'b1;
      t0 = edge_n;
      push(1'b1, t0 + 6);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check("press_busy", int'(busy), (k >= 3 && k <= 5) ? 1 : 0);
         check("press_a", int'(a), (k >= 6) ? 1 : 0);
      end
      btn_in = 1'b0;
      t0 = edge_n;
      push(1'b0, t0 + 6);
      cycles(10);
      check("release_a", int'(a), 0);

      // glitch: two cycles high is absorbed
      btn_in = 1'b1;
      cycles(2);
      btn_in = 1'b0;
      cycles(4);
      check("glitch_busy", int'(busy), 0);
      check("glitch_a", int'(a), 0);
      cycles(4);

      // bounce then release: one rise, one fall
      t0 = edge_n;
      push(1'b1, t0 + 11);
      push(1'b0, t0 + 17);
      for (int i = 0; i < 19; i++) begin
         btn_in = bpat[i][0];
         @(negedge clk);
      end
      cycles(6);
      check("bounce_a_final", int'(a), 0);
      check("bounce_q_empty", exp_q.size(), 0);

      // reset on edge 4 of a press aborts qualification
      btn_in = 1'b1;
      cycles(3);
      rst = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      btn_in = 1'b0;
      check("midrst_busy", int'(busy), 0);
      check("midrst_a", int'(a), 0);
      cycles(10);
      btn_in = 1'b1;
      t0 = edge_n;
      push(1'b1, t0 + 6);
      cycles(10);
      check("repress_a", int'(a), 1);
      btn_in = 1'b0;
      t0 = edge_n;
      push(1'b0, t0 + 6);
      cycles(10);

      // reset while a=1: a drops with no fall pulse
      btn_in = 1'b1;
      t0 = edge_n;
      push(1'b1, t0 + 6);
      cycles(8);
      rst = 1'b1;
      @(negedge clk);
      check("rst_high_a", int'(a), 0);
      btn_in = 1'b0;
      rst    = 1'b0;
      cycles(10);

`ifdef DEBOUNCE_PRESS_COUNT_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("cnt_cleared", int'(press_count), 0);
      for (int p = 1; p <= 257; p++) begin
         btn_in = 1'b1;
         t0 = edge_n;
         push(1'b1, t0 + 6);
         cycles(7);
         btn_in = 1'b0;
         t0 = edge_n;
         push(1'b0, t0 + 6);
         cycles(7);
         if (p == 1)   check("cnt_first", int'(press_count), 1);
         if (p == 256) check("cnt_wrap", int'(press_count), 0);
         if (p == 257) check("cnt_257", int'(press_count), 1);
      end
`endif

      cycles(10);
      check("final_q_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: timeout reached at edge %0d, expected completion", edge_n);
      $fatal(1);
   end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage placed directly upstream of the `top` sequencer: takes a raw, asynchronous, bouncy push-button/switch line and produces the clean, clock-synchronous level that drives `top.a`. Contains a multi-flop synchronizer, a 4-state debounce FSM with a stability counter, and single-cycle edge pulses for downstream logic.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal range ≥2.
- `DEBOUNCE_CYCLES`, default 4: consecutive equal synchronized samples required to commit a level change; legal range ≥2; counter width = $clog2(DEBOUNCE_CYCLES)+1.

- `clk`  in  1  single system clock; all flops on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_in`  in  1  raw asynchronous button/switch level.
- `a`  out  1  debounced level; connects to `top.a`.
- `rise`  out  1  one-cycle pulse in the cycle `a` goes 0→1.
- `fall`  out  1  one-cycle pulse in the cycle `a` goes 1→0.
- `busy`  out  1  high while a candidate transition is being qualified.
- `press_count`  out  8  number of committed rising edges (present only with `DEBOUNCE_PRESS_COUNT_EN`).

## Operation
- Synchronizer: `SYNC_STAGES`-deep shift chain clocked by `clk`; last stage = `s`. No logic between stages.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
  - IDLE_LO: `s`=1 → WAIT_HI, cnt=1; else stay.
  - WAIT_HI: `s`=0 → IDLE_LO, cnt=0 (glitch rejected, no output change). `s`=1 and cnt==DEBOUNCE_CYCLES-1 → IDLE_HI, `a`←1, `rise`←1. Otherwise cnt+1.
  - IDLE_HI / WAIT_LO: mirror image with `s`=0, `a`←0, `fall`←1.
- `busy` = 1 exactly in WAIT_HI/WAIT_LO.
- `rise`, `fall` registered; high for exactly one cycle; never simultaneous; never asserted outside a committed transition.
- Any opposite sample during WAIT restarts qualification from the IDLE state; the counter never saturates or wraps.
- Reset values: sync chain all 0, state IDLE_LO, cnt 0, `a`=0, `rise`=0, `fall`=0, `busy`=0, `press_count`=0.
- Reset asserted mid-WAIT: qualification aborted, no pulse. Reset while `a`=1: `a` drops to 0 on that edge with no `fall` pulse.
- `rst` has priority over all other events on the same edge.

## Timing
- `btn_in` stable before edge k (edge 1): `s` reflects it after edge SYNC_STAGES; `a` changes on edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: 6th edge), with `rise`/`fall` high in the same cycle as the new `a`.
- Minimum accepted pulse width: DEBOUNCE_CYCLES clock periods at `s`; shorter pulses are fully absorbed.
- Output-to-`top` path is purely registered; no combinational path from `btn_in` to any output.

## Configuration
- `DEBOUNCE_PRESS_COUNT_EN` defined: `press_count` port and 8-bit register exist; increments by 1 on every cycle `rise`=1; wraps 255→0; cleared by `rst`.
- Not defined: port and register absent; all other behaviour identical.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `btn_in`=1 → `a`=0, `rise`=`fall`=`busy`=0, `press_count`=0.
- Clean press: `btn_in` 0→1 held 10 cycles (defaults) → `a`=1 and `rise`=1 on 6th edge, `rise`=0 on 7th; `busy`=1 on edges 3–5.
- Glitch: `btn_in` high for 2 cycles then low → `a` stays 0, no `rise`, `busy` returns to 0.
- Bounce then release: pattern 1,0,1,1,0,1×6 then 0×8 → exactly one `rise`, one `fall`, `a` final 0.
- Reset mid-qualification: assert `rst` on edge 4 of a press → no `rise`, state IDLE_LO, re-press later commits normally.
- Counter wrap (macro on): 256 qualified presses → `press_count` returns to 0; 257th → 1.
